// File: rtl/ntt_stream_loader_pkg.sv
// Shared types and helpers for the NTT stream loader.
// Optional feature macro: NTT_LOADER_LAST_CHECK_EN (s_last framing check, see top).
package ntt_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TFB,
        ST_TFC,
        ST_MEM,
        ST_FLUSH,
        ST_DONE
    } loader_state_e;

    typedef enum logic [1:0] {
        SEC_TFB,
        SEC_TFC,
        SEC_MEM
    } loader_sec_e;

    // Words per row for a section.
    function automatic int sec_len(loader_sec_e sec, int bn);
        case (sec)
            SEC_TFB: return bn - 1;
            SEC_TFC: return bn - 2;
            default: return bn;
        endcase
    endfunction

    // Rows per section.
    function automatic int sec_rows(loader_sec_e sec, int k_ite, int ma);
        case (sec)
            SEC_TFB: return k_ite;
            SEC_TFC: return 1;
            default: return ma;
        endcase
    endfunction

    // First enabled section in stream order; FLUSH when nothing is left.
    function automatic loader_state_e first_state(logic [2:0] en);
        if (en[0]) return ST_TFB;
        if (en[1]) return ST_TFC;
        if (en[2]) return ST_MEM;
        return ST_FLUSH;
    endfunction

endpackage

// File: rtl/ntt_stream_loader_if.sv
// Valid/ready word stream feeding the NTT stream loader.
interface ntt_stream_loader_if #(
    parameter int D_WIDTH = 32
) ();
    logic               s_valid;
    logic               s_ready;
    logic [D_WIDTH-1:0] s_data;
    logic               s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/ntt_stream_loader_row_packer.sv
// Packs accepted words into a row buffer of runtime length `len` and flags
// the beat that completes a row; `row` already contains that final word.
module ntt_row_packer #(
    parameter int D_WIDTH = 32,
    parameter int MAX_LEN = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [$clog2(MAX_LEN+1)-1:0]   len,
    input  logic                           beat,
    input  logic [D_WIDTH-1:0]             data,
    output logic                           row_done,
    output logic [MAX_LEN*D_WIDTH-1:0]     row
);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [IDX_W-1:0]                  idx_q;
    logic [MAX_LEN-1:0][D_WIDTH-1:0]   words_q;
    logic [MAX_LEN-1:0][D_WIDTH-1:0]   row_d;
    logic                              at_end;

    assign at_end   = (LEN_W'(idx_q) == len - LEN_W'(1));
    assign row_done = beat & at_end;
    assign row      = row_d;

    // Bank index: advances per beat, clears when the row completes.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (beat) begin
            idx_q <= at_end ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Row buffer storage.
    // NOTE: no reset on the buffer: the index resets, and every bank is rewritten before a row can complete.
    always_ff @(posedge clk) begin
        if (beat) begin
            words_q[idx_q] <= data;
        end
    end

    // Row view including the word arriving this cycle.
    // NOTE: assign the default first so no path leaves row_d unassigned (no latch).
    always_comb begin
        row_d = words_q;
        if (beat) begin
            row_d[idx_q] = data;
        end
    end

endmodule

// File: rtl/ntt_stream_loader.sv
// Streaming preload engine: packs a word stream into TF base rows, the TF
// const row and coefficient memory rows, then pulses load_done.
// Optional feature macro: NTT_LOADER_LAST_CHECK_EN enables the s_last
// framing check driving a sticky err; otherwise s_last is ignored, err = 0.
module ntt_stream_loader
    import ntt_loader_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int BN      = 16,
    parameter int MA      = 64,
    parameter int K_ITE   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       go,
    input  logic [2:0]                 sec_en,
    ntt_stream_loader_if.slave         strm,
    output logic                       tfb_we,
    output logic [$clog2(K_ITE)-1:0]   tfb_addr,
    output logic [(BN-1)*D_WIDTH-1:0]  tfb_row,
    output logic                       tfc_we,
    output logic [(BN-2)*D_WIDTH-1:0]  tfc_row,
    output logic                       mem_we,
    output logic [$clog2(MA)-1:0]      mem_addr,
    output logic [BN*D_WIDTH-1:0]      mem_row,
    output logic                       busy,
    output logic                       load_done,
    output logic                       err
);
    localparam int LEN_W    = $clog2(BN + 1);
    localparam int MAX_ROWS = (MA > K_ITE) ? MA : K_ITE;
    localparam int ROW_W    = $clog2(MAX_ROWS + 1);
    localparam int TFB_AW   = $clog2(K_ITE);
    localparam int MEM_AW   = $clog2(MA);

    loader_state_e             state_q, state_d;
    loader_sec_e               cur_sec;
    logic [2:1]                sec_en_q;
    logic [ROW_W-1:0]          row_cnt_q;
    logic                      in_sec;
    logic                      beat;
    logic                      row_done;
    logic                      last_row;
    logic                      sec_end;
    logic [LEN_W-1:0]          pk_len;
    logic [BN*D_WIDTH-1:0]     pk_row;

    assign in_sec        = (state_q == ST_TFB) || (state_q == ST_TFC) || (state_q == ST_MEM);
    assign strm.s_ready  = in_sec;
    assign beat          = strm.s_valid & in_sec;
    assign busy          = (state_q != ST_IDLE);
    assign load_done     = (state_q == ST_DONE);
    assign pk_len        = LEN_W'(sec_len(cur_sec, BN));
    assign last_row      = (row_cnt_q == ROW_W'(sec_rows(cur_sec, K_ITE, MA) - 1));
    assign sec_end       = row_done & last_row;

    ntt_row_packer #(
        .D_WIDTH (D_WIDTH),
        .MAX_LEN (BN)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .len      (pk_len),
        .beat     (beat),
        .data     (strm.s_data),
        .row_done (row_done),
        .row      (pk_row)
    );

    // Section currently being filled (TFB outside the section states; no beats there).
    always_comb begin
        cur_sec = SEC_TFB;
        case (state_q)
            ST_TFC:  cur_sec = SEC_TFC;
            ST_MEM:  cur_sec = SEC_MEM;
            default: cur_sec = SEC_TFB;
        endcase
    end

    // Next-state: walk enabled sections in order, then FLUSH and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go) state_d = (sec_en == 3'b000) ? ST_DONE : first_state(sec_en);
            ST_TFB:   if (sec_end) state_d = first_state({sec_en_q, 1'b0});
            ST_TFC:   if (sec_end) state_d = first_state({sec_en_q[2], 2'b00});
            ST_MEM:   if (sec_end) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register and section enables captured at an accepted go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sec_en_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && go) begin
                sec_en_q <= sec_en[2:1];
            end
        end
    end

    // Row address: counts completed rows, back to 0 when a section ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q <= '0;
        end else if (sec_end) begin
            row_cnt_q <= '0;
        end else if (row_done) begin
            row_cnt_q <= row_cnt_q + ROW_W'(1);
        end
    end

    // Output write ports: one-cycle strobe with row and address registered alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tfb_we   <= 1'b0;
            tfb_addr <= '0;
            tfb_row  <= '0;
            tfc_we   <= 1'b0;
            tfc_row  <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_row  <= '0;
        end else begin
            tfb_we <= row_done && (state_q == ST_TFB);
            tfc_we <= row_done && (state_q == ST_TFC);
            mem_we <= row_done && (state_q == ST_MEM);
            if (row_done && state_q == ST_TFB) begin
                tfb_addr <= row_cnt_q[TFB_AW-1:0];
                tfb_row  <= pk_row[(BN-1)*D_WIDTH-1:0];
            end
            if (row_done && state_q == ST_TFC) begin
                tfc_row <= pk_row[(BN-2)*D_WIDTH-1:0];
            end
            if (row_done && state_q == ST_MEM) begin
                mem_addr <= row_cnt_q[MEM_AW-1:0];
                mem_row  <= pk_row;
            end
        end
    end

`ifdef NTT_LOADER_LAST_CHECK_EN
    // Sticky framing error: s_last must mark exactly the final word of each section.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state_q == ST_IDLE && go) begin
            err <= 1'b0;
        end else if (beat && (strm.s_last != sec_end)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = strm.s_last;
    assign err         = 1'b0;
`endif

endmodule

// File: doc/ntt_stream_loader.md
# ntt_stream_loader

Streaming preload engine for the NTT datapath. It accepts a valid/ready word stream and packs it into full-width rows. It writes twiddle-factor base rows, the twiddle-factor constant row, and the coefficient memory rows, then pulses `load_done` to launch the transform. It sits between the host/DMA stream and the `TF_gen` / `memory_rtl` write ports, and replaces backdoor array preloading.

## Interface
Parameters:
- `D_WIDTH`, 32: word width (modulus 65537 fits in 17 bits).
- `BN`, 16: memory bank count. The TF base row holds BN-1 words; the TF const row holds BN-2 words.
- `MA`, 64: memory rows (degree/BN).
- `K_ITE`, 4: TF base rows.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `go` in 1: start a load; sampled only in IDLE.
- `sec_en` in 3: section enables, sampled at `go`: [0] TF base, [1] TF const, [2] memory.
- `s_valid` in 1, `s_ready` out 1, `s_data` in D_WIDTH, `s_last` in 1: input stream.
- `tfb_we` out 1, `tfb_addr` out clog2(K_ITE), `tfb_row` out (BN-1)*D_WIDTH: TF base row write.
- `tfc_we` out 1, `tfc_row` out (BN-2)*D_WIDTH: TF const row write.
- `mem_we` out 1, `mem_addr` out clog2(MA), `mem_row` out BN*D_WIDTH: all-bank row write. Bank b occupies bits [b*D_WIDTH +: D_WIDTH].
- `busy` out 1, `load_done` out 1, `err` out 1.

## Operation
- FSM states: IDLE, TFB, TFC, MEM, FLUSH, DONE.
- IDLE→first enabled section on `go`, in the order TFB, TFC, MEM. If `sec_en`=0, go straight to DONE.
- A beat is accepted when `s_valid & s_ready`. Each accepted word goes into the row buffer at the bank index, then the index increments.
- When the index reaches the row length (TFB BN-1, TFC BN-2, MEM BN):
  - the row is copied to the output register and its write strobe is raised;
  - the index clears;
  - the row address increments.
- Section ends after its last row is accepted: K_ITE rows for TFB, 1 row for TFC, MA rows for MEM. Then the FSM moves to the next enabled section, or to FLUSH if none remain.
- FLUSH lasts 1 cycle and lets the final write issue. DONE lasts 1 cycle and asserts `load_done`, then returns to IDLE.
- Word order within a section: word n goes to row n/len, bank n%len. Example: memory word k*BN+b lands at bank b, address k.
- `go` outside IDLE is ignored. `s_data` in IDLE/FLUSH/DONE is not consumed.
- Row address counters wrap to 0 at section start. They never exceed their count.

## Timing
- Reset values: all outputs 0 (`s_ready`, strobes, addresses, rows, `busy`, `load_done`, `err`); FSM in IDLE.
- `s_ready`=1 in TFB/TFC/MEM, 0 otherwise. The output register is separate from the row buffer, so there is never a stall mid-section.
- Write strobe latency: the strobe is high the cycle after the completing beat, for exactly 1 cycle, with its row and address valid in that same cycle.
- `busy`=1 from the cycle after `go` until and including DONE.
- Minimum load time with no back-pressure: (total words) + 3 cycles from `go` to `load_done` high.
- Reset mid-load: everything aborts immediately. No partial row is ever written. The next `go` restarts at address 0.

## Configuration
- `NTT_LOADER_LAST_CHECK_EN` defined:
  - `s_last` must be high exactly on the final word of each enabled section.
  - Any mismatch (early, late or missing) sets a sticky `err`; loading continues.
  - `err` clears on the next accepted `go`.
- Not defined: `s_last` is ignored and `err` is tied to 0.

## Structure
- Package `ntt_loader_pkg` holds:
  - state enum `loader_state_e` and section enum `loader_sec_e`;
  - function `sec_len(sec, BN)` returning the row length;
  - function `sec_rows(sec, K_ITE, MA)` returning the row count.
- Sub-module `ntt_row_packer`:
  - parameters D_WIDTH and MAX_LEN=BN, with a runtime `len` input;
  - contains the index counter, row buffer and completion flag;
  - instantiated once in the loader.

## Test plan
Common setup: BN=16, MA=4, K_ITE=2.
- **Full load:** `go`, `sec_en`=3'b111, stream values 0..107 with no gaps → `tfb_we` at addr 0 (words 0..14) and addr 1 (words 15..29); one `tfc_we` (words 30..43); `mem_we` at addr 0..3, where addr 0 bank b = 44+b; `load_done` at cycle 111 after `go`.
- **Back-pressure:** same stream with `s_valid` toggling every cycle → identical writes and data; `load_done` later; no word lost or duplicated.
- **Memory only:** `sec_en`=3'b100 with 64 words → only `mem_we` pulses (4 of them); `tfb_we`/`tfc_we` stay 0.
- **Empty load:** `sec_en`=0 → `load_done` pulses once at cycle 2 after `go`; `s_ready` never rises.
- **Reset mid-load:** `rst_n` low after 20 memory words → all outputs 0 next edge, no further `mem_we`; a new `go` writes addr 0 first.
- **`s_last` check (`NTT_LOADER_LAST_CHECK_EN`):** `s_last` on TFB word 10 → `err`=1 and held through `load_done`; cleared by the next `go`.
